pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the pipelined CPU, replacing the hand-written per-stage latches (F/D, D/E, E/M, M/W) with one reusable block. It carries a control bundle, a data bundle and a hazard `Tnew` field. It adds a valid/ready handshake with an optional 2-entry skid buffer, which keeps `in_ready` registered, plus flush and bubble insertion. Each stage boundary instantiates one copy with its own widths.

---
 rtl/pipe_stage_reg.sv | 164 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register (F/D, D/E, E/M, M/W boundaries).
// Carries a control bundle, a data bundle and a hazard Tnew field behind a
// valid/ready handshake, with an optional 2-entry skid buffer, flush and
// bubble insertion.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   in_valid   upstream has an instruction
//   in_ready   stage can accept this cycle (registered when SKID=1)
//   in_ctrl    control bundle in
//   in_data    data bundle in
//   in_tnew    Tnew at the upstream stage
//   flush      discard all held entries
//   out_valid  head entry valid
//   out_ready  downstream accepts (0 = stall)
//   out_ctrl   head control, zero while out_valid=0
//   out_data   head data
//   out_tnew   head Tnew, zero while out_valid=0
//   occupancy  entries held (0..2)
module pipe_stage_reg #(
   parameter int unsigned CTRL_W   = 16,
   parameter int unsigned DATA_W   = 160,
   parameter int unsigned TNEW_W   = 2,
   parameter int unsigned TNEW_DEC = 1,
   parameter int unsigned SKID     = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic [TNEW_W-1:0] in_tnew,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [TNEW_W-1:0] out_tnew,
   output logic [1:0]        occupancy
);

   typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StFull = 2'd2} state_e;

   state_e            st_q, st_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
   logic [TNEW_W-1:0] main_tnew_q, main_tnew_d, skid_tnew_q, skid_tnew_d;
   logic              in_ready_q, in_ready_d;
   logic              accept, rel;
   logic [TNEW_W-1:0] tnew_cap;

   // Saturating one-step decrement of Tnew at capture time only.
   always_comb begin
      tnew_cap = in_tnew;
      if ((TNEW_DEC != 0) && (in_tnew != '0)) begin
         tnew_cap = in_tnew - TNEW_W'(1);
      end
   end

   assign out_valid = (st_q != StEmpty);
   // Without the skid entry, ready must look through to out_ready so a full
   // main register can be replaced in the same cycle it drains.
   assign in_ready  = (SKID != 0) ? in_ready_q : (reset & (!out_valid | out_ready));
   assign accept    = in_valid & in_ready;
   assign rel       = out_valid & out_ready;

   assign out_ctrl  = out_valid ? main_ctrl_q : '0;
   assign out_tnew  = out_valid ? main_tnew_q : '0;
   assign out_data  = main_data_q;

   always_comb begin
      occupancy = 2'd0;
      unique case (st_q)
         StOne:   occupancy = 2'd1;
         StFull:  occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   always_comb begin
      st_d        = st_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      main_tnew_d = main_tnew_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      skid_tnew_d = skid_tnew_q;

      unique case (st_q)
         StEmpty: begin
            if (accept) begin
               main_ctrl_d = in_ctrl;
               main_data_d = in_data;
               main_tnew_d = tnew_cap;
               st_d        = StOne;
            end
         end
         StOne: begin
            if (accept) begin
               if (rel) begin
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
                  main_tnew_d = tnew_cap;
               end else begin
                  // Only reachable with SKID=1; combinational ready blocks it otherwise.
                  skid_ctrl_d = in_ctrl;
                  skid_data_d = in_data;
                  skid_tnew_d = tnew_cap;
                  st_d        = StFull;
               end
            end else if (rel) begin
               st_d = StEmpty;
            end
         end
         StFull: begin
            if (rel) begin
               main_ctrl_d = skid_ctrl_q;
               main_data_d = skid_data_q;
               main_tnew_d = skid_tnew_q;
               st_d        = StOne;
            end
         end
         default: st_d = StEmpty;
      endcase

      // Flush drops any same-cycle accept: data is left as stored, ctrl/Tnew cleared.
      if (flush) begin
         st_d        = StEmpty;
         main_ctrl_d = '0;
         main_tnew_d = '0;
         main_data_d = main_data_q;
         skid_ctrl_d = '0;
         skid_tnew_d = '0;
         skid_data_d = skid_data_q;
      end

      in_ready_d = (st_d != StFull);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         st_q        <= StEmpty;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         main_tnew_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_tnew_q <= '0;
         in_ready_q  <= 1'b0;
      end else begin
         st_q        <= st_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         main_tnew_q <= main_tnew_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_tnew_q <= skid_tnew_d;
         in_ready_q  <= in_ready_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: SKID=1 with and without Tnew decrement
// (shared stimulus, table-driven) and SKID=0 (hand-written sequences).
module tb_pipe_stage_reg;

   logic clk;
   logic reset;

   // SKID=1 DUTs (a: TNEW_DEC=1, nd: TNEW_DEC=0) share inputs.
   logic         in_valid, flush, out_ready;
   logic [15:0]  in_ctrl;
   logic [159:0] in_data;
   logic [1:0]   in_tnew;
   logic         a_ird, a_ov, nd_ird, nd_ov;
   logic [15:0]  a_octrl, nd_octrl;
   logic [159:0] a_odata, nd_odata;
   logic [1:0]   a_otn, nd_otn, a_occ, nd_occ;

   // SKID=0 DUT.
   logic         ns_iv, ns_ordy, ns_ird, ns_ov;
   logic [7:0]   ns_ictrl, ns_octrl, ns_odata;
   logic [1:0]   ns_otn, ns_occ;

   assign in_data = {10{in_ctrl}};

   pipe_stage_reg #(.CTRL_W(16), .DATA_W(160), .TNEW_W(2), .TNEW_DEC(1), .SKID(1)) u_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_ird), .in_ctrl(in_ctrl),
      .in_data(in_data), .in_tnew(in_tnew), .flush(flush), .out_valid(a_ov),
      .out_ready(out_ready), .out_ctrl(a_octrl), .out_data(a_odata), .out_tnew(a_otn),
      .occupancy(a_occ)
   );

   pipe_stage_reg #(.CTRL_W(16), .DATA_W(160), .TNEW_W(2), .TNEW_DEC(0), .SKID(1)) u_nd (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(nd_ird), .in_ctrl(in_ctrl),
      .in_data(in_data), .in_tnew(in_tnew), .flush(flush), .out_valid(nd_ov),
      .out_ready(out_ready), .out_ctrl(nd_octrl), .out_data(nd_odata), .out_tnew(nd_otn),
      .occupancy(nd_occ)
   );

   pipe_stage_reg #(.CTRL_W(8), .DATA_W(8), .TNEW_W(2), .TNEW_DEC(1), .SKID(0)) u_ns (
      .clk(clk), .reset(reset), .in_valid(ns_iv), .in_ready(ns_ird), .in_ctrl(ns_ictrl),
      .in_data(ns_ictrl), .in_tnew(2'd1), .flush(1'b0), .out_valid(ns_ov),
      .out_ready(ns_ordy), .out_ctrl(ns_octrl), .out_data(ns_odata), .out_tnew(ns_otn),
      .occupancy(ns_occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] want);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, want);
      end
   endtask

   typedef struct {
      logic        iv;
      logic [15:0] ctrl;
      logic [1:0]  tnew;
      logic        fl;
      logic        ordy;
      logic        ov;
      logic [15:0] octrl;
      logic [1:0]  otn;
      logic [1:0]  otn_nd;
      logic [1:0]  occ;
      logic        ird;
   } vec_t;

   vec_t tbl[20];

   logic [7:0] exp_q[$];
   logic [7:0] nxt;
   logic       acc, rls;
   int         got, nacc;

   initial begin
      // iv ctrl tnew fl ordy | ov octrl otn otn_nd occ ird  (state after the edge)
      tbl[0]  = '{1'b1, 16'h0001, 2'd2, 1'b0, 1'b1, 1'b1, 16'h0001, 2'd1, 2'd2, 2'd1, 1'b1};
      tbl[1]  = '{1'b1, 16'h0002, 2'd2, 1'b0, 1'b1, 1'b1, 16'h0002, 2'd1, 2'd2, 2'd1, 1'b1};
      tbl[2]  = '{1'b1, 16'h0003, 2'd2, 1'b0, 1'b1, 1'b1, 16'h0003, 2'd1, 2'd2, 2'd1, 1'b1};
      tbl[3]  = '{1'b1, 16'h0004, 2'd2, 1'b0, 1'b1, 1'b1, 16'h0004, 2'd1, 2'd2, 2'd1, 1'b1};
      tbl[4]  = '{1'b1, 16'h0005, 2'd2, 1'b0, 1'b1, 1'b1, 16'h0005, 2'd1, 2'd2, 2'd1, 1'b1};
      tbl[5]  = '{1'b0, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 2'd0, 2'd0, 1'b1};
      tbl[6]  = '{1'b1, 16'h00A0, 2'd3, 1'b0, 1'b0, 1'b1, 16'h00A0, 2'd2, 2'd3, 2'd1, 1'b1};
      tbl[7]  = '{1'b1, 16'h00B0, 2'd3, 1'b0, 1'b0, 1'b1, 16'h00A0, 2'd2, 2'd3, 2'd2, 1'b0};
      tbl[8]  = '{1'b1, 16'h00C0, 2'd3, 1'b0, 1'b0, 1'b1, 16'h00A0, 2'd2, 2'd3, 2'd2, 1'b0};
      tbl[9]  = '{1'b1, 16'h00C0, 2'd3, 1'b0, 1'b1, 1'b1, 16'h00B0, 2'd2, 2'd3, 2'd1, 1'b1};
      tbl[10] = '{1'b1, 16'h00C0, 2'd3, 1'b0, 1'b1, 1'b1, 16'h00C0, 2'd2, 2'd3, 2'd1, 1'b1};
      tbl[11] = '{1'b0, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 2'd0, 2'd0, 1'b1};
      tbl[12] = '{1'b1, 16'h0011, 2'd0, 1'b0, 1'b1, 1'b1, 16'h0011, 2'd0, 2'd0, 2'd1, 1'b1};
      tbl[13] = '{1'b1, 16'h0012, 2'd3, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 2'd0, 2'd0, 1'b1};
      tbl[14] = '{1'b1, 16'h0021, 2'd1, 1'b0, 1'b0, 1'b1, 16'h0021, 2'd0, 2'd1, 2'd1, 1'b1};
      tbl[15] = '{1'b1, 16'h0022, 2'd2, 1'b0, 1'b0, 1'b1, 16'h0021, 2'd0, 2'd1, 2'd2, 1'b0};
      tbl[16] = '{1'b1, 16'h0023, 2'd2, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 2'd0, 2'd0, 1'b1};
      tbl[17] = '{1'b0, 16'h0000, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 2'd0, 2'd0, 1'b1};
      tbl[18] = '{1'b1, 16'h0031, 2'd2, 1'b0, 1'b1, 1'b1, 16'h0031, 2'd1, 2'd2, 2'd1, 1'b1};
      tbl[19] = '{1'b1, 16'h0032, 2'd2, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 2'd0, 2'd0, 1'b1};

      reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_ctrl = '0; in_tnew = '0;
      ns_iv = 1'b0; ns_ordy = 1'b0; ns_ictrl = '0;

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_out_valid", a_ov, 0);
      chk("rst_in_ready", a_ird, 0);
      chk("rst_occ", a_occ, 0);
      chk("rst_ctrl", a_octrl, 0);
      chk("rst_data", a_odata, 0);
      chk("rst_tnew", a_otn, 0);
      chk("rst_ns_in_ready", ns_ird, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_rel_in_ready", a_ird, 1);
      chk("rst_rel_ns_in_ready", ns_ird, 1);

      // Table-driven SKID=1 sequence.
      for (int i = 0; i < 20; i++) begin
         in_valid  = tbl[i].iv;
         in_ctrl   = tbl[i].ctrl;
         in_tnew   = tbl[i].tnew;
         flush     = tbl[i].fl;
         out_ready = tbl[i].ordy;
         @(negedge clk);
         chk($sformatf("v%0d_out_valid", i), a_ov, tbl[i].ov);
         chk($sformatf("v%0d_out_ctrl", i), a_octrl, tbl[i].octrl);
         chk($sformatf("v%0d_out_tnew", i), a_otn, tbl[i].otn);
         chk($sformatf("v%0d_occ", i), a_occ, tbl[i].occ);
         chk($sformatf("v%0d_in_ready", i), a_ird, tbl[i].ird);
         chk($sformatf("v%0d_nd_out_tnew", i), nd_otn, tbl[i].otn_nd);
         chk($sformatf("v%0d_nd_out_ctrl", i), nd_octrl, tbl[i].octrl);
         if (tbl[i].ov) begin
            chk($sformatf("v%0d_out_data", i), a_odata, {10{tbl[i].octrl}});
            chk($sformatf("v%0d_nd_out_data", i), nd_odata, {10{tbl[i].octrl}});
         end
      end

      // Reset mid-stream with two entries held; reset also beats flush.
      in_valid = 1'b1; flush = 1'b0; out_ready = 1'b0; in_tnew = 2'd2;
      in_ctrl = 16'h0041;
      @(negedge clk);
      in_ctrl = 16'h0042;
      @(negedge clk);
      chk("mid_occ_full", a_occ, 2);
      chk("mid_in_ready_low", a_ird, 0);
      reset = 1'b0; flush = 1'b1; in_ctrl = 16'h0043;
      @(negedge clk);
      chk("mid_rst_out_valid", a_ov, 0);
      chk("mid_rst_in_ready", a_ird, 0);
      chk("mid_rst_occ", a_occ, 0);
      chk("mid_rst_ctrl", a_octrl, 0);
      chk("mid_rst_data", a_odata, 0);
      chk("mid_rst_tnew", a_otn, 0);
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("mid_rel_in_ready", a_ird, 1);
      chk("mid_rel_out_valid", a_ov, 0);

      // SKID=0: combinational ready follows out_ready while holding an entry.
      ns_iv = 1'b1; ns_ictrl = 8'h51; ns_ordy = 1'b0;
      @(negedge clk);
      chk("ns_hold_valid", ns_ov, 1);
      chk("ns_hold_ctrl", ns_octrl, 8'h51);
      chk("ns_hold_tnew", ns_otn, 0);
      chk("ns_stall_in_ready", ns_ird, 0);
      ns_iv = 1'b0; ns_ordy = 1'b1;
      #1;
      chk("ns_go_in_ready", ns_ird, 1);
      @(negedge clk);
      chk("ns_drain_valid", ns_ov, 0);

      // SKID=0 streaming with out_ready toggling every cycle: scoreboard order.
      nxt = 8'h60; got = 0; nacc = 0;
      for (int c = 0; c < 24; c++) begin
         ns_iv = 1'b1; ns_ictrl = nxt; ns_ordy = c[0];
         #1;
         acc = ns_iv & ns_ird;
         rls = ns_ov & ns_ordy;
         if (ns_ov && !ns_ordy) chk("ns_stall_ready", ns_ird, 0);
         if (ns_ordy) chk("ns_ready_when_ordy", ns_ird, 1);
         if (rls) begin
            if (exp_q.size() == 0) chk("ns_dup", 1, 0);
            else chk("ns_order", ns_octrl, exp_q.pop_front());
            got++;
         end
         if (acc) begin
            exp_q.push_back(nxt);
            nxt = nxt + 8'd1;
            nacc++;
         end
         @(negedge clk);
         chk("ns_occ_max1", (ns_occ > 2'd1), 0);
      end
      ns_iv = 1'b0; ns_ordy = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (ns_ov) begin
            if (exp_q.size() == 0) chk("ns_dup", 1, 0);
            else chk("ns_order", ns_octrl, exp_q.pop_front());
            got++;
         end
         @(negedge clk);
      end
      chk("ns_drained", exp_q.size(), 0);
      chk("ns_count", got, nacc);
      chk("ns_progress", (nacc >= 10), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
